arm_reg_file_sb: RTL
====================

# arm_reg_file_sb

ARM register file with an integrated pending-write scoreboard, sitting between the decode stage and write-back. It holds r0–r14 in negedge-written storage and returns the supplied PC+8 value for r15. It also tracks how many in-flight instructions target each register and drives a decode-stage stall when a source operand is still pending. Write-back updates land at the falling edge, so decode can read them combinationally in the same cycle.

## Interface
Parameters:
- N, 32, data width
- ADDR_W, 4, register address width (16 architectural registers)

Ports:
- clk  in  1  clock; storage writes on negedge, scoreboard on posedge
- rst  in  1  reset, asynchronous, active-high
- rn_addr, rm_addr, rs_addr  in  ADDR_W  source register addresses
- rn_used, rm_used, rs_used  in  1  source is actually read by the decoded instruction
- rn_data, rm_data, rs_data  out  N  combinational read data
- pc_plus8  in  N  value returned for any read of r15
- issue_en  in  1  decoded instruction leaves ID this cycle with a register destination
- issue_dst  in  ADDR_W  destination of the issuing instruction
- kill_en  in  1  one in-flight instruction is squashed
- kill_dst  in  ADDR_W  destination of the squashed instruction
- wb_en  in  1  write-back valid
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  N  write-back data
- stall  out  1  a used source is pending
- sb_err  out  1  sticky scoreboard overflow/underflow flag

## Operation
- Storage: 15 × N registers (r0–r14). At negedge, if wb_en and wb_addr≠15, the value reg[wb_addr] is set to wb_data.
- r15 is never stored. Reads of r15 return pc_plus8. Writes to r15 are ignored here (the PC is owned by fetch).
- Reads are asynchronous. A read issued in the same cycle as a write-back returns the new value after the negedge.
- Scoreboard: each register r0–r14 has a 2-bit pending counter (max 3). Register r15 is never tracked.
- Counter update at posedge: count += (issue_en && issue_dst==r) − (wb_en && wb_addr==r) − (kill_en && kill_dst==r).
  - The issue and decrement terms apply independently and simultaneously. For example, issue and wb to the same register in one cycle gives a net 0.
  - Overflow (result > 3): the counter saturates at 3 and sb_err is set.
  - Underflow (result < 0): the counter holds at 0 and sb_err is set.
- The effective pending count for a register is count − (wb_en && wb_addr==r). A write landing this cycle does not stall.
- stall = OR over the sources x ∈ {rn, rm, rs} of (x_used && x_addr≠15 && effective_count[x_addr] > 0). The output is combinational.
- The issue_en qualification belongs to the pipeline: issue_en while stall=1 is illegal. The block does not block it internally.
- sb_err is cleared only by rst.

## Timing
- Reset: all registers 0, all counters 0, sb_err 0. Reset is asynchronous and acts on both the negedge storage and the posedge scoreboard. Consequently rn/rm/rs_data = 0 (or pc_plus8 for r15) and stall=0 during reset.
- Reset in mid-operation discards all pending counts immediately.
- Write latency: data is visible on the read ports ½ cycle after the wb cycle starts (after the negedge). There is no read-port latency.
- Scoreboard latency: a new issue raises stall for dependent reads from the next cycle.

## Configuration
- REGFILE_SB_ERR_EN
  - Defined: overflow/underflow detection and the sticky sb_err are implemented.
  - Undefined: sb_err is tied 0 and saturation/hold still apply silently.

## Structure
- Shared package holds the following constants: ADDR_W, PC_IDX=15, SB_CNT_W=2, SB_CNT_MAX=3.
- Sub-module sb_counter: a single 2-bit saturating up/down counter with inc, dec_wb, dec_kill, err outputs and async reset. It is instantiated 15 times.
- The storage array is written in a negedge always block inside the top level.

## Test plan
- Reset, then read r0, r7, and r15 with pc_plus8=0x108 → data 0, 0, 0x108; stall=0; sb_err=0.
- wb_en, wb_addr=3, wb_data=0xDEADBEEF, with rn_addr=3 in the same cycle → rn_data=0xDEADBEEF after the negedge and stays; write to r15 → no change anywhere.
- Issue dst=5, next cycle rm_addr=5 with rm_used=1 → stall=1. In the wb cycle for r5 → stall=0 and rm_data equals the new value.
- Issue dst=2 three times, then a fourth issue → count 3 and sb_err=1 with the macro defined (0 without it). Next, 3 wbs to r2 → count 0, and rn_addr=2 does not stall.
- Issue dst=4 and kill dst=4 in later cycles → count returns to 0. Same-cycle issue+wb on r4 with count=1 → count stays 1.
- Assert rst asynchronously mid-cycle with counters non-zero → stall drops to 0 immediately and all data reads 0.

Source files
------------

// File: rtl/arm_reg_file_sb_pkg.sv
// Shared constants and types for the ARM register file with pending-write scoreboard.
package arm_reg_file_sb_pkg;
   localparam int ADDR_W     = 4;
   localparam int PC_IDX     = 15;
   localparam int NUM_REGS   = 15;
   localparam int SB_CNT_W   = 2;
   localparam int SB_CNT_MAX = 3;

   typedef logic [SB_CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/arm_reg_file_sb_sb_counter.sv
// Saturating 2-bit pending-write counter for one architectural register.
// err pulses in any cycle whose net update would overflow or underflow.
module sb_counter
   import arm_reg_file_sb_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    inc,
   input  logic    dec_wb,
   input  logic    dec_kill,
   output sb_cnt_t count,
   output logic    err
);
   localparam int SUM_W = SB_CNT_W + 2;
   localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(SB_CNT_MAX);

   sb_cnt_t                 count_reg;
   sb_cnt_t                 count_next;
   logic signed [SUM_W-1:0] sum;

   always_comb begin
      sum = signed'({2'b00, count_reg})
          + signed'({{(SUM_W-1){1'b0}}, inc})
          - signed'({{(SUM_W-1){1'b0}}, dec_wb})
          - signed'({{(SUM_W-1){1'b0}}, dec_kill});
      count_next = sum[SB_CNT_W-1:0];
      err        = 1'b0;
      if (sum[SUM_W-1]) begin
         // more retirements than outstanding writes: hold at zero
         count_next = '0;
         err        = 1'b1;
      end else if (sum > MAX_S) begin
         count_next = SB_CNT_W'(SB_CNT_MAX);
         err        = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_reg <= '0;
      else     count_reg <= count_next;
   end

   assign count = count_reg;
endmodule

// File: rtl/arm_reg_file_sb.sv
// ARM r0-r14 register file (negedge write, async read, r15 = pc_plus8) with a
// per-register pending-write scoreboard driving decode stall. REGFILE_SB_ERR_EN enables sticky sb_err.
module arm_reg_file_sb #(
   parameter int N      = 32,
   parameter int ADDR_W = arm_reg_file_sb_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rn_addr,
   input  logic [ADDR_W-1:0] rm_addr,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic              rn_used,
   input  logic              rm_used,
   input  logic              rs_used,
   output logic [N-1:0]      rn_data,
   output logic [N-1:0]      rm_data,
   output logic [N-1:0]      rs_data,
   input  logic [N-1:0]      pc_plus8,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_dst,
   input  logic              kill_en,
   input  logic [ADDR_W-1:0] kill_dst,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [N-1:0]      wb_data,
   output logic              stall,
   output logic              sb_err
);
   import arm_reg_file_sb_pkg::*;

   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

   logic [N-1:0] regs [0:NUM_REGS-1];

   // Falling-edge write lets decode see write-back data in the same cycle.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_en && wb_addr != PC_ADDR) begin
         regs[wb_addr] <= wb_data;
      end
   end

   sb_cnt_t                 cnt [NUM_REGS];
   logic [NUM_REGS-1:0]     err_vec;
   logic [(2**ADDR_W)-1:0]  pending;

   assign pending[PC_IDX] = 1'b0;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      logic inc;
      logic dec_wb;
      logic dec_kill;

      assign inc      = issue_en && issue_dst == ADDR_W'(gi);
      assign dec_wb   = wb_en    && wb_addr   == ADDR_W'(gi);
      assign dec_kill = kill_en  && kill_dst  == ADDR_W'(gi);

      sb_counter u_cnt (
         .clk      (clk),
         .rst      (rst),
         .inc      (inc),
         .dec_wb   (dec_wb),
         .dec_kill (dec_kill),
         .count    (cnt[gi]),
         .err      (err_vec[gi])
      );

      // A write-back landing this cycle already satisfies one pending entry.
      assign pending[gi] = cnt[gi] > SB_CNT_W'(dec_wb);
   end

   logic [ADDR_W-1:0] src_addr [3];
   logic [2:0]        src_used;
   logic [N-1:0]      src_data [3];
   logic [2:0]        src_pend;

   assign src_addr[0] = rn_addr;
   assign src_addr[1] = rm_addr;
   assign src_addr[2] = rs_addr;
   assign src_used    = {rs_used, rm_used, rn_used};

   for (genvar gi = 0; gi < 3; gi++) begin : g_src
      assign src_data[gi] = (src_addr[gi] == PC_ADDR) ? pc_plus8 : regs[src_addr[gi]];
      assign src_pend[gi] = src_used[gi] && (src_addr[gi] != PC_ADDR) && pending[src_addr[gi]];
   end

   assign rn_data = src_data[0];
   assign rm_data = src_data[1];
   assign rs_data = src_data[2];
   assign stall   = |src_pend;

`ifdef REGFILE_SB_ERR_EN
   logic sb_err_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           sb_err_reg <= 1'b0;
      else if (|err_vec) sb_err_reg <= 1'b1;
   end

   assign sb_err = sb_err_reg;
`else
   logic unused_err;

   assign unused_err = |err_vec;
   assign sb_err     = 1'b0;
`endif
endmodule
